// File: rtl/jt900h_pkg.sv
// jt900h_pkg: shared encodings for the jt900h micro-DMA transfer engine
// (FSM states, transfer modes, access sizes, register-file groups).
package jt900h_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_SRC,
        ST_LD_SRC_W,
        ST_LD_DST,
        ST_LD_DST_W,
        ST_LD_CNT,
        ST_LD_CNT_W,
        ST_RD,
        ST_WR,
        ST_WB_SRC,
        ST_WB_DST,
        ST_WB_CNT
    } udma_state_e;

    localparam logic [2:0] MODE_DST_INC = 3'b000;
    localparam logic [2:0] MODE_DST_DEC = 3'b001;
    localparam logic [2:0] MODE_SRC_INC = 3'b010;
    localparam logic [2:0] MODE_SRC_DEC = 3'b011;
    localparam logic [2:0] MODE_FIXED   = 3'b100;
    localparam logic [2:0] MODE_COUNTER = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    localparam logic [1:0] GRP_SRC = 2'd0;
    localparam logic [1:0] GRP_DST = 2'd1;
    localparam logic [1:0] GRP_CNT = 2'd2;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_WORD = 3'b010;
    localparam logic [2:0] WE_LONG = 3'b100;

    // count/mode word layout: count in [15:0], dmam[4:0] in [20:16]
    localparam int DMAM_LSB = 16;

    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'b11) ? SZ_BYTE : s;
    endfunction

endpackage

// File: rtl/jt900h_udma_addr.sv
// jt900h_udma_addr: next source or destination address for one transfer step;
// only the low 24 bits move, the top byte is carried through untouched.
module jt900h_udma_addr
    import jt900h_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  mode_i,
    input  logic [1:0]  size_i,
    input  logic        dst_i,
    output logic [31:0] next_o
);
    logic [23:0] step;
    logic        inc, dec;

    always_comb begin
        step = (norm_size(size_i) == SZ_LONG) ? 24'd4 :
               (norm_size(size_i) == SZ_WORD) ? 24'd2 : 24'd1;
        // counter mode always bumps the source by one regardless of size
        if (mode_i == MODE_COUNTER)
            step = 24'd1;
        inc = dst_i ? (mode_i == MODE_DST_INC) : (mode_i == MODE_SRC_INC || mode_i == MODE_COUNTER);
        dec = dst_i ? (mode_i == MODE_DST_DEC) : (mode_i == MODE_SRC_DEC);
        next_o = {addr_i[31:24], inc ? addr_i[23:0] + step : dec ? addr_i[23:0] - step : addr_i[23:0]};
    end

endmodule

// File: rtl/jt900h_udma_xfer.sv
// jt900h_udma_xfer: micro-DMA transfer engine; per serviced request it loads
// src/dst/count from the register file, moves one unit on the bus, writes back.
module jt900h_udma_xfer
    import jt900h_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [3:0]  req,
    output logic [5:0]  rf_sel,
    output logic [2:0]  rf_we,
    output logic [31:0] rf_dout,
    input  logic [31:0] rf_din,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic        busy,
    output logic [3:0]  tc_irq
);
    udma_state_e state_q, state_d;
    logic [3:0]  pend_q, pend_d, clr;
    logic [1:0]  ch_q, ch_d, pick, grp;
    logic [31:0] src_q, src_d, dst_q, dst_d, data_q, data_d, src_nx, dst_nx;
    logic [15:0] cnt_q, cnt_d, cnt_nx;
    logic [4:0]  dmam_q, dmam_d;
    logic        sel_en;

    jt900h_udma_addr u_src (
        .addr_i (src_q),
        .mode_i (dmam_q[4:2]),
        .size_i (dmam_q[1:0]),
        .dst_i  (1'b0),
        .next_o (src_nx)
    );

    jt900h_udma_addr u_dst (
        .addr_i (dst_q),
        .mode_i (dmam_q[4:2]),
        .size_i (dmam_q[1:0]),
        .dst_i  (1'b1),
        .next_o (dst_nx)
    );

    assign pick   = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
    assign cnt_nx = cnt_q - 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ch_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            dmam_q  <= '0;
            data_q  <= '0;
        end else if (cen) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            dmam_q  <= dmam_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        dmam_d  = dmam_q;
        data_d  = data_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: if (|pend_q) begin
                ch_d    = pick;
                clr     = 4'b0001 << pick;
                state_d = ST_LD_SRC;
            end
            ST_LD_SRC:   state_d = ST_LD_SRC_W;
            ST_LD_SRC_W: begin
                src_d   = rf_din;
                state_d = ST_LD_DST;
            end
            ST_LD_DST:   state_d = ST_LD_DST_W;
            ST_LD_DST_W: begin
                dst_d   = rf_din;
                state_d = ST_LD_CNT;
            end
            ST_LD_CNT:   state_d = ST_LD_CNT_W;
            ST_LD_CNT_W: begin
                cnt_d   = rf_din[15:0];
                dmam_d  = rf_din[DMAM_LSB +: 5];
                state_d = (rf_din[DMAM_LSB + 2 +: 3] == MODE_COUNTER) ? ST_WB_SRC : ST_RD;
            end
            ST_RD: if (bus_ack) begin
                data_d  = bus_din;
                state_d = ST_WR;
            end
            ST_WR:       state_d = bus_ack ? ST_WB_SRC : ST_WR;
            ST_WB_SRC:   state_d = ST_WB_DST;
            ST_WB_DST:   state_d = ST_WB_CNT;
            default:     state_d = ST_IDLE;
        endcase
        // a request landing on the cycle its channel is picked stays pending
        pend_d = (pend_q & ~clr) | req;
    end

    always_comb begin
        sel_en   = 1'b1;
        grp      = GRP_SRC;
        rf_we    = WE_NONE;
        rf_dout  = '0;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = '0;
        bus_size = SZ_BYTE;
        tc_irq   = '0;
        case (state_q)
            ST_LD_SRC, ST_LD_SRC_W: grp = GRP_SRC;
            ST_LD_DST, ST_LD_DST_W: grp = GRP_DST;
            ST_LD_CNT, ST_LD_CNT_W: grp = GRP_CNT;
            ST_RD: begin
                sel_en   = 1'b0;
                bus_rd   = 1'b1;
                bus_addr = src_q[23:0];
                bus_size = norm_size(dmam_q[1:0]);
            end
            ST_WR: begin
                sel_en   = 1'b0;
                bus_wr   = 1'b1;
                bus_addr = dst_q[23:0];
                bus_size = norm_size(dmam_q[1:0]);
            end
            ST_WB_SRC: begin
                rf_we   = WE_LONG;
                rf_dout = src_nx;
            end
            ST_WB_DST: begin
                grp     = GRP_DST;
                rf_we   = WE_LONG;
                rf_dout = dst_nx;
            end
            ST_WB_CNT: begin
                grp     = GRP_CNT;
                rf_we   = WE_WORD;
                rf_dout = {16'h0000, cnt_nx};
                tc_irq  = (cnt_nx == 16'h0000) ? 4'b0001 << ch_q : 4'b0000;
            end
            default: sel_en = 1'b0;
        endcase
        rf_sel = sel_en ? {grp, ch_q, 2'b00} : 6'd0;
    end

    assign bus_dout = data_q;
    // pending work keeps busy up across the IDLE cycle between queued transfers
    assign busy     = (state_q != ST_IDLE) || (|pend_q);

endmodule
